// File: rtl/pll_rst_ctrl.sv
// -----------------------------------------------------------------------------
// pll_rst_ctrl
//
// Reset manager living in the PLL output clock domain. The raw PLL lock flag
// is synchronised and then filtered (it must stay high for LOCK_FILTER
// consecutive cycles). After that the N_DOMAINS reset outputs are released
// one after another, RELEASE_GAP cycles apart, in index order. A lock loss
// or a force_rst request pulls every domain back into reset at once and
// restarts the filter. Lock losses seen while releasing or running are
// counted in a saturating debug counter.
//
// Ports:
//   clk           PLL output clock
//   rst_n         asynchronous active-low board / power-on reset
//   pll_locked    raw PLL lock flag, asynchronous to clk
//   force_rst     level request: hold every domain in reset while high
//   loss_clr      single-cycle pulse: clear loss_cnt
//   rst_n_out     per-domain active-low resets (async assert, sync release)
//   locked_stable high while every domain is released
//   loss_cnt      saturating count of lock losses seen while releasing/running
//
// If the PLL stops clk while unlocked, the outputs hold their last value
// until clk resumes. The top level must therefore gate rst_n with an
// external POR to guarantee reset in that situation.
// -----------------------------------------------------------------------------
module pll_rst_ctrl #(
  parameter int N_DOMAINS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RELEASE_GAP = 8,
  parameter int W_LOSS      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_locked,
  input  logic                 force_rst,
  input  logic                 loss_clr,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 locked_stable,
  output logic [W_LOSS-1:0]    loss_cnt
);

  localparam int FILT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int GAP_W  = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam int DOM_W  = (N_DOMAINS   > 1) ? $clog2(N_DOMAINS)   : 1;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
  localparam logic [DOM_W-1:0]  DOM_LAST  = DOM_W'(N_DOMAINS - 1);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [DOM_W-1:0]       dom_idx_q, dom_idx_d;
  logic [N_DOMAINS-1:0]   rst_out_q, rst_out_d;
  logic                   locked_q, locked_d;
  logic [W_LOSS-1:0]      loss_q, loss_d;

  logic lock_sync;
  logic loss_inc;

  assign lock_sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    dom_idx_d  = dom_idx_q;
    rst_out_d  = rst_out_q;
    locked_d   = locked_q;
    loss_inc   = 1'b0;

    case (state_q)
      WAIT: begin
        if (lock_sync && !force_rst) begin
          if (filt_cnt_q == FILT_LAST) begin
            rst_out_d[0] = 1'b1;
            gap_cnt_d    = '0;
            dom_idx_d    = DOM_W'(1);
            if (N_DOMAINS == 1) begin
              state_d  = RUN;
              locked_d = 1'b1;
            end else begin
              state_d = REL;
            end
          end else begin
            filt_cnt_d = filt_cnt_q + FILT_W'(1);
          end
        end else begin
          // Any glitch in the filter window simply restarts it.
          filt_cnt_d = '0;
        end
      end

      REL, RUN: begin
        if (!lock_sync || force_rst) begin
          // Abort: every domain back into reset at once.
          rst_out_d  = '0;
          locked_d   = 1'b0;
          filt_cnt_d = '0;
          state_d    = WAIT;
          // Only a real lock loss is counted; force_rst alone is not.
          loss_inc   = !lock_sync;
        end else if (state_q == REL) begin
          if (gap_cnt_q == GAP_LAST) begin
            for (int i = 0; i < N_DOMAINS; i++) begin
              if (DOM_W'(i) == dom_idx_q) rst_out_d[i] = 1'b1;
            end
            gap_cnt_d = '0;
            dom_idx_d = dom_idx_q + DOM_W'(1);
            if (dom_idx_q == DOM_LAST) begin
              state_d  = RUN;
              locked_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      default: begin
        rst_out_d  = '0;
        locked_d   = 1'b0;
        filt_cnt_d = '0;
        state_d    = WAIT;
      end
    endcase

    // A clear coinciding with a counted loss keeps that one loss.
    loss_d = loss_q;
    if (loss_clr) begin
      loss_d = loss_inc ? W_LOSS'(1) : '0;
    end else if (loss_inc && (loss_q != '1)) begin
      loss_d = loss_q + W_LOSS'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchroniser is reset too, so lock must be re-qualified
      // from scratch after every board reset.
      state_q    <= WAIT;
      sync_q     <= '0;
      filt_cnt_q <= '0;
      gap_cnt_q  <= '0;
      dom_idx_q  <= '0;
      rst_out_q  <= '0;
      locked_q   <= 1'b0;
      loss_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the synchroniser shift depends on this.
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      filt_cnt_q <= filt_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      dom_idx_q  <= dom_idx_d;
      rst_out_q  <= rst_out_d;
      locked_q   <= locked_d;
      loss_q     <= loss_d;
    end
  end

  assign rst_n_out     = rst_out_q;
  assign locked_stable = locked_q;
  assign loss_cnt      = loss_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_ctrl
//
// Scoreboard bench for pll_rst_ctrl (N_DOMAINS=2, SYNC_STAGES=2,
// LOCK_FILTER=16, RELEASE_GAP=8, W_LOSS=2). The stimulus thread pushes the
// expected outputs for specific clock edges into a queue, derived from the
// documented latencies. A monitor pops them on the falling edge after the
// matching rising edge and compares them.
// -----------------------------------------------------------------------------
module tb_pll_rst_ctrl;

  localparam int N_DOM  = 2;
  localparam int W_LOSS = 2;

  logic              clk;
  logic              rst_n;
  logic              pll_locked;
  logic              force_rst;
  logic              loss_clr;
  logic [N_DOM-1:0]  rst_n_out;
  logic              locked_stable;
  logic [W_LOSS-1:0] loss_cnt;

  pll_rst_ctrl #(
    .N_DOMAINS  (N_DOM),
    .SYNC_STAGES(2),
    .LOCK_FILTER(16),
    .RELEASE_GAP(8),
    .W_LOSS     (W_LOSS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_rst    (force_rst),
    .loss_clr     (loss_clr),
    .rst_n_out    (rst_n_out),
    .locked_stable(locked_stable),
    .loss_cnt     (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen since time 0; stable when read on a falling edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int                cyc;
    string             tag;
    logic [N_DOM-1:0]  rst;
    logic              ls;
    logic [W_LOSS-1:0] loss;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  task automatic sb_push(input string tag, input int at, input logic [N_DOM-1:0] rst,
                         input logic ls, input logic [W_LOSS-1:0] loss);
    exp_t e;
    e.cyc  = at;
    e.tag  = tag;
    e.rst  = rst;
    e.ls   = ls;
    e.loss = loss;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      sb_e = sb_q.pop_front();
      check({sb_e.tag, ".rst_n_out"},     32'(rst_n_out),     32'(sb_e.rst));
      check({sb_e.tag, ".locked_stable"}, 32'(locked_stable), 32'(sb_e.ls));
      check({sb_e.tag, ".loss_cnt"},      32'(loss_cnt),      32'(sb_e.loss));
    end
  end

  task automatic to_neg(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Safety net in case something stalls the stimulus thread.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int b;
  int exp_loss;

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    force_rst  = 1'b0;
    loss_clr   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset.rst_n_out",     32'(rst_n_out),     32'h0);
    check("reset.locked_stable", 32'(locked_stable), 32'h0);
    check("reset.loss_cnt",      32'(loss_cnt),      32'h0);

    // Default release sequence: lock high before edge 1 -> 18 / 26.
    rst_n = 1'b1; pll_locked = 1'b1; b = cyc;
    sb_push("def_e17", b + 17, 2'b00, 1'b0, 2'd0);
    sb_push("def_e18", b + 18, 2'b01, 1'b0, 2'd0);
    sb_push("def_e25", b + 25, 2'b01, 1'b0, 2'd0);
    sb_push("def_e26", b + 26, 2'b11, 1'b1, 2'd0);
    to_neg(b + 30);

    // Lock loss in RUN: all resets fall 2 edges after the first low sample.
    b = cyc; pll_locked = 1'b0;
    sb_push("loss_pre",  b + 2, 2'b11, 1'b1, 2'd0);
    sb_push("loss_fall", b + 3, 2'b00, 1'b0, 2'd1);
    to_neg(b + 5);

    // Relock, then force_rst for one cycle in REL after domain 0 release.
    b = cyc; pll_locked = 1'b1;
    sb_push("relock_e17", b + 17, 2'b00, 1'b0, 2'd1);
    sb_push("relock_e18", b + 18, 2'b01, 1'b0, 2'd1);
    sb_push("relock_e20", b + 20, 2'b01, 1'b0, 2'd1);
    to_neg(b + 20);
    force_rst = 1'b1;
    sb_push("force_abort", b + 21, 2'b00, 1'b0, 2'd1);
    to_neg(b + 21);
    force_rst = 1'b0;
    sb_push("force_e36", b + 36, 2'b00, 1'b0, 2'd1);
    sb_push("force_e37", b + 37, 2'b01, 1'b0, 2'd1);
    sb_push("force_e44", b + 44, 2'b01, 1'b0, 2'd1);
    sb_push("force_e45", b + 45, 2'b11, 1'b1, 2'd1);
    to_neg(b + 48);

    // force_rst from RUN, re-release, then async reset mid-REL.
    b = cyc; force_rst = 1'b1;
    sb_push("frun_abort", b + 1, 2'b00, 1'b0, 2'd1);
    to_neg(b + 1);
    force_rst = 1'b0;
    sb_push("frun_e16", b + 16, 2'b00, 1'b0, 2'd1);
    sb_push("frun_e17", b + 17, 2'b01, 1'b0, 2'd1);
    to_neg(b + 20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.rst_n_out",     32'(rst_n_out),     32'h0);
    check("async_rst.locked_stable", 32'(locked_stable), 32'h0);
    check("async_rst.loss_cnt",      32'(loss_cnt),      32'h0);
    @(negedge clk);

    // Restart from WAIT with a one-cycle lock glitch sampled at edge 10.
    rst_n = 1'b1; b = cyc;
    sb_push("glitch_e18", b + 18, 2'b00, 1'b0, 2'd0);
    sb_push("glitch_e27", b + 27, 2'b00, 1'b0, 2'd0);
    sb_push("glitch_e28", b + 28, 2'b01, 1'b0, 2'd0);
    sb_push("glitch_e35", b + 35, 2'b01, 1'b0, 2'd0);
    sb_push("glitch_e36", b + 36, 2'b11, 1'b1, 2'd0);
    to_neg(b + 9);
    pll_locked = 1'b0;
    to_neg(b + 10);
    pll_locked = 1'b1;
    to_neg(b + 40);

    // Five lock losses with a 2-bit counter: saturates at 3.
    exp_loss = 0;
    for (int i = 0; i < 5; i++) begin
      b = cyc; pll_locked = 1'b0;
      exp_loss = (exp_loss < 3) ? exp_loss + 1 : 3;
      sb_push($sformatf("sat%0d_fall", i), b + 3, 2'b00, 1'b0, W_LOSS'(exp_loss));
      to_neg(b + 4);
      b = cyc; pll_locked = 1'b1;
      sb_push($sformatf("sat%0d_rel", i), b + 18, 2'b01, 1'b0, W_LOSS'(exp_loss));
      to_neg(b + 19);
    end

    // Sixth loss with a coincident loss_clr -> 1.
    b = cyc; pll_locked = 1'b0;
    sb_push("clr6_pre",  b + 2, 2'b01, 1'b0, 2'd3);
    sb_push("clr6_fall", b + 3, 2'b00, 1'b0, 2'd1);
    to_neg(b + 2);
    loss_clr = 1'b1;
    to_neg(b + 3);
    loss_clr = 1'b0;

    // Plain loss_clr while waiting -> 0.
    to_neg(b + 6);
    loss_clr = 1'b1;
    sb_push("clr_wait", b + 7, 2'b00, 1'b0, 2'd0);
    to_neg(b + 7);
    loss_clr = 1'b0;

    // Drain: every pushed expectation must have been consumed.
    to_neg(cyc + 3);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
